prog_loader: RTL and testbench

Boot-time program loader that fills the processor's 4K-word instruction memory from a byte stream, then releases the core. It is the write side of the instruction-fetch port: it parses a length header, packs bytes into 32-bit words, and issues one word-addressed write per word from address 0 upward. While loading it holds the CPU in reset; once the last word has landed it asserts `done` and drops the hold.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/word_assembler.sv | 36 +++
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states, sizes and header check for the boot program loader
package prog_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_HDR0  = 3'd1;
  localparam state_t ST_HDR1  = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_FLUSH = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERR   = 3'd6;

  // A count of exactly 2**addr_w words is legal: it fills the memory.
  function automatic logic hdr_overflow(input logic [CNT_W-1:0] n, input int addr_w);
    return {16'd0, n} > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs four stream bytes, MSB first, into one 32-bit word
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int BC_W = $clog2(WORD_BYTES);

  // Only the first three bytes need storage; the fourth is taken straight from din.
  logic [23:0]     shreg;
  logic [BC_W-1:0] byte_cnt;

  assign word_valid = en && (byte_cnt == BC_W'(WORD_BYTES - 1));
  assign word       = {shreg, din};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (en) begin
      shreg    <= {shreg[15:0], din};
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - fills instruction memory from a length-prefixed byte stream, then releases the CPU
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t           state;
  logic [7:0]       n_hi;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] hdr_n;
  logic             accept;
  logic             start_ok;
  logic             asm_en;
  logic             word_valid;
  logic [31:0]      asm_word;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_HDR0, ST_HDR1, ST_DATA: in_ready = 1'b1;
      default:                   in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign asm_en   = accept && (state == ST_DATA);
  assign hdr_n    = {n_hi, in_data};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .en         (asm_en),
    .din        (in_data),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      n_hi     <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // Address advances after the strobe so it equals the word index while mem_we is high.
      if (mem_we) mem_addr <= mem_addr + 1'b1;

      if (start_ok) begin
        state    <= ST_HDR0;
        word_cnt <= '0;
        mem_addr <= '0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end else begin
        case (state)
          ST_HDR0: begin
            if (accept) begin
              n_hi  <= in_data;
              state <= ST_HDR1;
            end
          end
          ST_HDR1: begin
            if (accept) begin
              n_words <= hdr_n;
              if (hdr_overflow(hdr_n, ADDR_W)) begin
                state <= ST_ERR;
                err   <= 1'b1;
              end else if (hdr_n == '0) begin
                state <= ST_FLUSH;
              end else begin
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (word_valid) begin
              mem_we   <= 1'b1;
              mem_din  <= asm_word;
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt + 1'b1 == n_words) state <= ST_FLUSH;
            end
          end
          // One idle cycle so the final write lands before the CPU is released.
          ST_FLUSH: state <= ST_DONE;
          ST_DONE: begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
          ST_ERR:  state <= ST_ERR;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 12;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  logic [ADDR_W+31:0] exp_q[$];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops the next expected {addr, data}.
  always @(negedge clk) begin
    if (mem_we) begin
      logic [ADDR_W+31:0] e;
      we_count++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none", mem_addr, mem_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
        check("wr_data", mem_din, e[31:0]);
      end
    end
  end

  task automatic expect_write(input int addr, input logic [31:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  // Presents one byte and returns at the negedge after it was accepted, in_valid still high.
  task automatic send_byte(input logic [7:0] b, input bit thr);
    int n;
    n = 0;
    if (thr) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_stream(input byte_q_t s, input bit thr);
    foreach (s[i]) send_byte(s[i], thr);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after the last accepted byte (edge E).
  task automatic check_done_tail(input string tag);
    check({tag, "_done_e0"}, 32'(done), 32'd0);
    check({tag, "_rdy_e0"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_done_e1"}, 32'(done), 32'd0);
    check({tag, "_hold_e1"}, 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check({tag, "_done_e2"}, 32'(done), 32'd1);
    check({tag, "_hold_e2"}, 32'(cpu_hold), 32'd0);
    check({tag, "_rdy_e2"}, 32'(in_ready), 32'd0);
    check({tag, "_err_e2"}, 32'(err), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, mem_din, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t s;
    int      wc;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic load, back-to-back
    expect_write(0, 32'hDEADBEEF);
    expect_write(1, 32'h01234567);
    pulse_start();
    check("basic_rdy_hdr0", 32'(in_ready), 32'd1);
    s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    send_stream(s, 1'b0);
    check_done_tail("basic");
    check("basic_writes", 32'(we_count), 32'd2);

    // Throttled input, with a start pulse mid-payload that must be ignored
    wc = we_count;
    expect_write(0, 32'hDEADBEEF);
    expect_write(1, 32'h01234567);
    pulse_start();
    s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(s, 1'b1);
    pulse_start();
    s = '{8'h01, 8'h23, 8'h45, 8'h67};
    send_stream(s, 1'b1);
    check_done_tail("throttle");
    check("throttle_writes", 32'(we_count - wc), 32'd2);

    // Zero-length load
    wc = we_count;
    pulse_start();
    s = '{8'h00, 8'h00};
    send_stream(s, 1'b0);
    check_done_tail("zero");
    check("zero_writes", 32'(we_count - wc), 32'd0);

    // Overflow header 4097 words
    wc = we_count;
    pulse_start();
    s = '{8'h10, 8'h01};
    send_stream(s, 1'b0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_hold", 32'(cpu_hold), 32'd1);
    check("ovf_rdy", 32'(in_ready), 32'd0);
    in_data  = 8'h77;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("ovf_rdy_hold", 32'(in_ready), 32'd0);
      check("ovf_err_sticky", 32'(err), 32'd1);
    end
    in_valid = 1'b0;
    check("ovf_writes", 32'(we_count - wc), 32'd0);
    expect_write(0, 32'hAABBCCDD);
    pulse_start();
    check("ovf_restart_err", 32'(err), 32'd0);
    check("ovf_restart_rdy", 32'(in_ready), 32'd1);
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(s, 1'b0);
    check_done_tail("ovf_reload");

    // Full capacity, word i = i, extra bytes offered afterwards
    wc = we_count;
    s = '{8'h10, 8'h00};
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      expect_write(i, 32'(i));
      s.push_back(8'h00);
      s.push_back(8'h00);
      s.push_back(8'(i >> 8));
      s.push_back(8'(i));
    end
    pulse_start();
    send_stream(s, 1'b0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    check_done_tail("full");
    repeat (3) begin
      @(negedge clk);
      check("full_extra_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("full_writes", 32'(we_count - wc), 32'd4096);
    check("full_addr_wrap", 32'(mem_addr), 32'd0);

    // Reset mid-word, then a fresh load
    expect_write(0, 32'h11223344);
    pulse_start();
    s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(s, 1'b0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wc = we_count;
    expect_write(0, 32'hA1B2C3D4);
    pulse_start();
    s = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_stream(s, 1'b0);
    check_done_tail("after_rst");
    check("after_rst_writes", 32'(we_count - wc), 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
